// File: rtl/codificador_secuencial.sv
// Sequential 8-to-3 priority encoder. Captures a request vector and emits the
// index of each set bit, highest first, one code per valid/ready handshake,
// then pulses done for one cycle.
module codificador_secuencial (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D,
  input  logic       load,
  input  logic       en,
  input  logic       ready,
  output logic [2:0] Q,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] count
);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [3:0] count_q, count_d;
  logic       done_q, done_d;

  logic [2:0] top_idx;
  logic       serving;
  logic       handshake;
  logic [7:0] pending_cleared;

  // Index of the highest set bit of pending; later iterations win.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending_q[i]) begin
        top_idx = i[2:0];
      end
    end
  end

  assign serving         = (state_q == StServe);
  assign handshake       = serving && en && ready;
  assign pending_cleared = pending_q & ~(8'd1 << top_idx);

  // Next-state logic for the FSM, pending vector, code counter and done pulse.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load && en) begin
          pending_d = D;
          count_d   = 4'd0;
          if (D != 8'h00) begin
            state_d = StServe;
          end else begin
            // Empty vector: nothing to serve, report completion right away.
            done_d = 1'b1;
          end
        end
      end
      StServe: begin
        if (handshake) begin
          pending_d = pending_cleared;
          count_d   = count_q + 4'd1;
          if (pending_cleared == 8'h00) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 8'h00;
      count_q   <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Outputs come from registered state; only valid is qualified by en.
  assign Q     = serving ? top_idx : 3'd0;
  assign valid = serving && en;
  assign busy  = serving;
  assign done  = done_q;
  assign count = count_q;

endmodule
